wrr_pkt_sched: RTL and testbench

- Weighted round-robin packet scheduler. Shares one downstream valid/ready stream among N upstream packet sources.
- Each port's weight is the number of whole packets it may send per turn.
- The grant is locked from the first beat to the last beat of a packet, so packets never interleave.
- Sits in front of a shared egress resource (bus, FIFO, link). Weights are runtime-configurable.

---
 rtl/wrr_pkt_sched.sv | 137 +++++++++++++
 tb/tb_wrr_pkt_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wrr_pkt_sched.sv
// rtl/wrr_pkt_sched.sv - weighted round-robin packet scheduler for N valid/ready sources
//
// Shares one egress stream among N packet sources. Each port may send
// weight[i] whole packets per turn. The grant is held from the first to the
// last beat of a packet, so packets never interleave.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_valid/in_data/in_last/in_ready   per-port ingress streams (port i data at [i*DW +: DW])
//   out_valid/out_data/out_last/out_ready   shared egress stream
//   cfg_we/cfg_idx/cfg_weight          weight register write port (weight 0 disables a port)
//   cur_port, busy    port holding the grant, high while a packet is being transferred
module wrr_pkt_sched #(
    parameter int N          = 4,
    parameter int DW         = 32,
    parameter int WW         = 4,
    parameter int WEIGHT_RST = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N-1:0]            in_valid,
    input  logic [N*DW-1:0]         in_data,
    input  logic [N-1:0]            in_last,
    output logic [N-1:0]            in_ready,
    output logic                    out_valid,
    output logic [DW-1:0]           out_data,
    output logic                    out_last,
    input  logic                    out_ready,
    input  logic                    cfg_we,
    input  logic [$clog2(N)-1:0]    cfg_idx,
    input  logic [WW-1:0]           cfg_weight,
    output logic [$clog2(N)-1:0]    cur_port,
    output logic                    busy
);

    localparam int IW = $clog2(N);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_XFER = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] cur_q, cur_d;
    logic [WW-1:0] credit_q, credit_d;
    logic [WW-1:0] weight_q [N];

    logic [N-1:0]  elig;
    logic [IW-1:0] win;
    logic          found;
    logic          keep;
    logic [IW:0]   pos;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            elig[i] = in_valid[i] && (weight_q[i] != '0);
        end
    end

    // First eligible port at or after ptr, wrapping modulo N. pos is one bit
    // wider than an index so ptr+k never overflows before the wrap.
    always_comb begin
        win   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr_q} + (IW+1)'(k);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            if (!found && elig[pos[IW-1:0]]) begin
                found = 1'b1;
                win   = pos[IW-1:0];
            end
        end
    end

    // Remaining credit on an still-eligible current port continues the turn.
    assign keep = (credit_q != '0) && elig[cur_q];

    assign busy      = (state_q == S_XFER);
    assign cur_port  = cur_q;
    assign out_valid = busy && in_valid[cur_q];
    assign out_data  = in_data[cur_q*DW +: DW];
    assign out_last  = busy && in_last[cur_q];
    assign in_ready  = (busy && out_ready) ? (N'(1) << cur_q) : '0;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cur_d    = cur_q;
        credit_d = credit_q;
        if (state_q == S_IDLE) begin
            if (keep) begin
                state_d = S_XFER;
            end else if (found) begin
                // New turn: any leftover credit of the previous port is dropped.
                state_d  = S_XFER;
                cur_d    = win;
                credit_d = weight_q[win];
                ptr_d    = (win == IW'(N-1)) ? '0 : win + 1'b1;
            end
        end else begin
            if (out_valid && out_ready && out_last) begin
                state_d = S_IDLE;
                if (credit_q != '0) begin
                    credit_d = credit_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            cur_q    <= '0;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cur_q    <= cur_d;
            credit_q <= credit_d;
        end
    end

    // Indices with no matching register (cfg_idx >= N) simply write nothing.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                weight_q[i] <= WW'(WEIGHT_RST);
            end else if (cfg_we && (cfg_idx == IW'(i))) begin
                weight_q[i] <= cfg_weight;
            end
        end
    end

endmodule

// File: tb/tb_wrr_pkt_sched.sv
// tb/tb_wrr_pkt_sched.sv - directed scoreboard bench for wrr_pkt_sched
module tb_wrr_pkt_sched;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int WW = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      in_valid, in_last, in_ready;
    logic [N*DW-1:0]   in_data;
    logic              out_valid, out_last, out_ready;
    logic [DW-1:0]     out_data;
    logic              cfg_we;
    logic [IW-1:0]     cfg_idx;
    logic [WW-1:0]     cfg_weight;
    logic [IW-1:0]     cur_port;
    logic              busy;

    always #5 clk = ~clk;

    wrr_pkt_sched #(.N(N), .DW(DW), .WW(WW), .WEIGHT_RST(1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_weight(cfg_weight),
        .cur_port(cur_port), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    logic [DW:0] sb[$];
    int pkt_cnt[N], beat_cnt[N], pkt_lim[N], len[N], exp_pkt[N];
    logic [N-1:0] en;
    int cyc = 0;
    int last_hs = -1;
    bit gap_chk = 0;
    bit pat_on = 0;
    bit p1_mon = 0;
    bit p2_mon = 0;
    bit p1_seen = 0;
    bit mirror_bad = 0;
    bit port_bad = 0;
    logic [3:0] pat = 4'b1001;

    function automatic logic [DW-1:0] word(int p, int k, int b);
        return {p[7:0], k[15:0], b[7:0]};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            in_valid[i] = en[i] && (pkt_cnt[i] < pkt_lim[i]);
            in_last[i]  = (beat_cnt[i] == len[i] - 1);
            in_data[i*DW +: DW] = word(i, pkt_cnt[i], beat_cnt[i]);
        end
        out_ready = pat_on ? pat[cyc % 4] : 1'b1;
    endtask

    task automatic clr_src();
        for (int i = 0; i < N; i++) begin
            pkt_cnt[i] = 0; beat_cnt[i] = 0; pkt_lim[i] = 1000; len[i] = 1; exp_pkt[i] = 0;
        end
        en = '0; pat_on = 0; gap_chk = 0; last_hs = -1;
        p1_mon = 0; p2_mon = 0;
        sb.delete();
    endtask

    // Sample at the falling edge, then advance sources on what was accepted.
    task automatic tick();
        logic [N-1:0] rdy;
        logic hs;
        logic [DW:0] got, exp;
        @(negedge clk);
        hs  = out_valid & out_ready;
        rdy = in_ready;
        got = {out_last, out_data};
        if (p1_mon && in_ready[1]) p1_seen = 1;
        if (p2_mon && busy) begin
            if (in_ready[2] !== out_ready || in_ready[1:0] !== 2'b00 || in_ready[3] !== 1'b0) mirror_bad = 1;
            if (cur_port !== 2'd2) port_bad = 1;
        end
        if (hs && !reset) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_underflow: observed beat %0h expected none", got);
            end else begin
                exp = sb.pop_front();
                chk("egress_beat", 64'(got), 64'(exp));
            end
            if (gap_chk && last_hs >= 0) chk("beat_gap", 64'(cyc - last_hs), 64'd2);
            last_hs = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (!reset && in_valid[i] && rdy[i]) begin
                if (in_last[i]) begin
                    beat_cnt[i] = 0;
                    pkt_cnt[i]++;
                end else begin
                    beat_cnt[i]++;
                end
            end
        end
        drive_inputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clr_src();
        drive_inputs();
        tick();
        tick();
        reset = 1'b0;
        clr_src();
        drive_inputs();
    endtask

    task automatic cfg(int idx, int w);
        cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_weight = WW'(w);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic expect_pkt(int p, int nb);
        for (int b = 0; b < nb; b++) sb.push_back({(b == nb - 1), word(p, exp_pkt[p], b)});
        exp_pkt[p]++;
    endtask

    task automatic run(string tag, int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL %s_timeout: observed %0d beats outstanding expected 0", tag, sb.size());
        end
    endtask

    initial begin
        int ord2[7];
        ord2 = '{0, 0, 0, 1, 2, 2, 3};
        cfg_we = 1'b0; cfg_idx = '0; cfg_weight = '0;
        reset = 1'b1;
        clr_src();
        en = '1;
        drive_inputs();
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_cur_port",  64'(cur_port),  64'd0);

        // Equal weights, 1-beat packets: 0,1,2,3 with a beat every other cycle.
        do_reset();
        en = '1;
        gap_chk = 1;
        drive_inputs();
        for (int r = 0; r < 2; r++) for (int p = 0; p < N; p++) expect_pkt(p, 1);
        run("rr_equal", 100);

        // Weights {3,1,2,1}, 2-beat packets, two full rounds.
        do_reset();
        cfg(0, 3);
        cfg(2, 2);
        for (int i = 0; i < N; i++) len[i] = 2;
        en = '1;
        drive_inputs();
        for (int r = 0; r < 2; r++) for (int j = 0; j < 7; j++) expect_pkt(ord2[j], 2);
        run("wrr_3121", 200);

        // Port1 disabled by weight 0 while requesting.
        do_reset();
        cfg(1, 0);
        en = 4'b0111;
        p1_seen = 0;
        p1_mon = 1;
        drive_inputs();
        for (int r = 0; r < 3; r++) begin expect_pkt(0, 1); expect_pkt(2, 1); end
        run("weight0", 100);
        chk("port1_ready_never", 64'(p1_seen), 64'd0);

        // Port0 (weight 4) sends one packet then goes idle; port3 takes over.
        do_reset();
        cfg(0, 4);
        en = 4'b1001;
        pkt_lim[0] = 1;
        gap_chk = 1;
        drive_inputs();
        expect_pkt(0, 1); expect_pkt(3, 1); expect_pkt(3, 1); expect_pkt(3, 1);
        run("forfeit", 100);

        // 4-beat packet from port2 under a 1,0,0,1 egress back-pressure pattern.
        do_reset();
        en = 4'b0100;
        len[2] = 4;
        pkt_lim[2] = 1;
        pat_on = 1;
        mirror_bad = 0; port_bad = 0;
        p2_mon = 1;
        drive_inputs();
        expect_pkt(2, 4);
        run("backpressure", 60);
        chk("release_after_last", 64'(busy), 64'd0);
        chk("in_ready_mirror", 64'(mirror_bad), 64'd0);
        chk("cur_port_held", 64'(port_bad), 64'd0);

        // Reset during beat 2 of a 4-beat packet, with port0 weight raised.
        do_reset();
        cfg(0, 3);
        en = 4'b0100;
        len[2] = 4;
        pkt_lim[2] = 1;
        drive_inputs();
        sb.push_back({1'b0, word(2, 0, 0)});
        run("pre_reset", 40);
        chk("beat2_presented", 64'(out_valid), 64'd1);
        reset = 1'b1;
        tick();
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        clr_src();
        // ptr=0 and weight0=1 give 0,1,3 order; stale ptr or weight would not.
        en = 4'b1011;
        drive_inputs();
        for (int r = 0; r < 2; r++) begin expect_pkt(0, 1); expect_pkt(1, 1); expect_pkt(3, 1); end
        run("post_reset", 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
